// File: rtl/styler_pkg.sv
// Shared constants for the glyph styler: attribute bit positions, config map,
// ctrl bit positions and the compacted attribute bundle carried into stage 2.
package styler_pkg;

  localparam int ATTR_XMIRROR   = 0;
  localparam int ATTR_BOLD      = 1;
  localparam int ATTR_FAINT     = 2;
  localparam int ATTR_ITALIC    = 3;
  localparam int ATTR_BLINK     = 4;
  localparam int ATTR_INVERSE   = 5;
  localparam int ATTR_HIDDEN    = 6;
  localparam int ATTR_UNDERLINE = 7;
  localparam int ATTR_DBL_UNDER = 8;
  localparam int ATTR_DOTTED    = 9;
  localparam int ATTR_STRIKE    = 10;
  localparam int ATTR_OVERLINE  = 11;
  localparam int ATTR_CURSOR    = 12;

  localparam logic [1:0] CFG_CTRL   = 2'd0;
  localparam logic [1:0] CFG_CSTART = 2'd1;
  localparam logic [1:0] CFG_CEND   = 2'd2;
  localparam logic [1:0] CFG_FCLR   = 2'd3;

  localparam int CTRL_BLINK_EN     = 0;
  localparam int CTRL_LINE_EN      = 1;
  localparam int CTRL_CURSOR_EN    = 2;
  localparam int CTRL_CURSOR_BLINK = 3;
  localparam int CTRL_EXTRA_BOLD   = 4;
  localparam int CTRL_W            = 5;

  localparam logic [7:0] CTRL_RST = 8'h07;

  typedef struct packed {
    logic faint;
    logic blink;
    logic inverse;
    logic hidden;
    logic underline;
    logic dbl_under;
    logic dotted;
    logic strike;
    logic overline;
    logic cursor;
  } s2_attr_t;

  // Keep only the attribute bits that stage 2 still needs.
  function automatic s2_attr_t pick_s2_attr(input logic [15:0] a);
    s2_attr_t s;
    s.faint     = a[ATTR_FAINT];
    s.blink     = a[ATTR_BLINK];
    s.inverse   = a[ATTR_INVERSE];
    s.hidden    = a[ATTR_HIDDEN];
    s.underline = a[ATTR_UNDERLINE];
    s.dbl_under = a[ATTR_DBL_UNDER];
    s.dotted    = a[ATTR_DOTTED];
    s.strike    = a[ATTR_STRIKE];
    s.overline  = a[ATTR_OVERLINE];
    s.cursor    = a[ATTR_CURSOR];
    return s;
  endfunction

endpackage

// File: rtl/styler_phase_gen.sv
// Frame counter producing the faint, cursor and blink phases; a config clear
// takes priority over a frame tick in the same cycle.
module styler_phase_gen #(
  parameter int BLINK_SHIFT = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick,
  input  logic fclr,
  output logic faint_ph,
  output logic blink_ph,
  output logic cursor_ph
);

  logic [BLINK_SHIFT:0] fcnt_q, fcnt_d;

  // Next frame-count value.
  always_comb begin
    fcnt_d = fcnt_q;
    if (fclr) begin
      fcnt_d = '0;
    end else if (frame_tick) begin
      fcnt_d = fcnt_q + 1'b1;
    end else begin
      fcnt_d = fcnt_q;
    end
  end

  // Frame-count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

  assign faint_ph  = fcnt_q[0];
  assign blink_ph  = fcnt_q[BLINK_SHIFT];
  assign cursor_ph = fcnt_q[BLINK_SHIFT-1];

endmodule

// File: rtl/glyph_styler_pipe.sv
// Two-stage glyph styler: stage 1 shapes the glyph (mirror/bold/italic),
// stage 2 applies phase-dependent effects, decoration lines and the cursor.
module glyph_styler_pipe
  import styler_pkg::*;
#(
  parameter int GLYPH_W     = 8,
  parameter int GLYPH_H     = 16,
  parameter int SL_W        = $clog2(GLYPH_H),
  parameter int BLINK_SHIFT = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [7:0]         cfg_wdata,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SL_W-1:0]    in_scanline,
  input  logic [GLYPH_W-1:0] in_bitmap,
  input  logic [15:0]        in_attr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [GLYPH_W-1:0] out_row,
  output logic [SL_W-1:0]    out_scanline
);

  function automatic logic [GLYPH_W-1:0] bit_rev(input logic [GLYPH_W-1:0] v);
    logic [GLYPH_W-1:0] o;
    for (int i = 0; i < GLYPH_W; i++) o[i] = v[GLYPH_W-1-i];
    return o;
  endfunction

  function automatic logic [GLYPH_W-1:0] alt_mask();
    logic [GLYPH_W-1:0] m;
    for (int i = 0; i < GLYPH_W; i++) m[i] = ((i % 2) == 0);
    return m;
  endfunction

  localparam logic [GLYPH_W-1:0] DOT_MASK  = alt_mask();
  localparam logic [SL_W-1:0]    SL_LAST   = SL_W'(GLYPH_H - 1);
  localparam logic [SL_W-1:0]    SL_DUL    = SL_W'(GLYPH_H - 3);
  localparam logic [SL_W-1:0]    SL_STRIKE = SL_W'(GLYPH_H / 2 - 1);
  localparam logic [SL_W-1:0]    SL_HALF   = SL_W'(GLYPH_H / 2);

  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [SL_W-1:0]    cstart_q, cstart_d, cend_q, cend_d;
  logic               fclr;
  logic               faint_ph, blink_ph, cursor_ph;

  logic               s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [GLYPH_W-1:0] s1_row_q, s1_row_d, s2_row_q, s2_row_d;
  logic [SL_W-1:0]    s1_sl_q, s1_sl_d, s2_sl_q, s2_sl_d;
  s2_attr_t           s1_attr_q, s1_attr_d;
  logic               s1_load, s2_load;

  logic unused_ok;
  assign unused_ok = ^{in_attr[15:13], cfg_wdata[7:5]};

  // Config register writes; address 3 only pulses the frame-counter clear.
  always_comb begin
    ctrl_d   = ctrl_q;
    cstart_d = cstart_q;
    cend_d   = cend_q;
    fclr     = 1'b0;
    if (cfg_we) begin
      case (cfg_addr)
        CFG_CTRL:   ctrl_d   = cfg_wdata[CTRL_W-1:0];
        CFG_CSTART: cstart_d = cfg_wdata[SL_W-1:0];
        CFG_CEND:   cend_d   = cfg_wdata[SL_W-1:0];
        CFG_FCLR:   fclr     = 1'b1;
        default:    fclr     = 1'b0;
      endcase
    end else begin
      fclr = 1'b0;
    end
  end

  styler_phase_gen #(.BLINK_SHIFT(BLINK_SHIFT)) u_phase (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .fclr      (fclr),
    .faint_ph  (faint_ph),
    .blink_ph  (blink_ph),
    .cursor_ph (cursor_ph)
  );

  // Handshake: in_ready is forced high while reset holds the pipe empty.
  assign s2_load  = ~s2_v_q | out_ready;
  assign s1_load  = ~s1_v_q | s2_load;
  assign in_ready = ~rst_n | ~s1_v_q | ~s2_v_q | out_ready;

  logic [GLYPH_W-1:0] mir_row, bold_row, xbold_row, ital_row;
  assign mir_row   = in_attr[ATTR_XMIRROR] ? bit_rev(in_bitmap) : in_bitmap;
  assign bold_row  = in_attr[ATTR_BOLD] ? (mir_row | (mir_row >> 1)) : mir_row;
  assign xbold_row = (in_attr[ATTR_BOLD] & ctrl_q[CTRL_EXTRA_BOLD]) ?
                     (bold_row | (bold_row >> 2)) : bold_row;
  assign ital_row  = (in_attr[ATTR_ITALIC] && (in_scanline < SL_HALF)) ?
                     (xbold_row >> 1) : xbold_row;

  // Stage 1 next state.
  always_comb begin
    s1_v_d    = s1_v_q;
    s1_row_d  = s1_row_q;
    s1_sl_d   = s1_sl_q;
    s1_attr_d = s1_attr_q;
    if (s1_load) begin
      s1_v_d    = in_valid;
      s1_row_d  = ital_row;
      s1_sl_d   = in_scanline;
      s1_attr_d = pick_s2_attr(in_attr);
    end else begin
      s1_v_d    = s1_v_q;
    end
  end

  logic               sl_ok, blink_hit, line_row, line_on, cursor_hit;
  logic [GLYPH_W-1:0] faint_row, blank_row, line_row_px, inv_row, cur_row, styled;

  assign sl_ok     = int'(s1_sl_q) < GLYPH_H;
  assign blink_hit = s1_attr_q.blink & ctrl_q[CTRL_BLINK_EN] & blink_ph;
  assign line_row  = ((s1_attr_q.underline | s1_attr_q.dbl_under) & (s1_sl_q == SL_LAST)) |
                     (s1_attr_q.dbl_under & (s1_sl_q == SL_DUL)) |
                     (s1_attr_q.strike & (s1_sl_q == SL_STRIKE)) |
                     (s1_attr_q.overline & (s1_sl_q == '0));
  assign line_on   = ctrl_q[CTRL_LINE_EN] & ~blink_hit & line_row;
  // An empty or inverted cursor window (start > end) never matches.
  assign cursor_hit = s1_attr_q.cursor & ctrl_q[CTRL_CURSOR_EN] &
                      (~ctrl_q[CTRL_CURSOR_BLINK] | cursor_ph) &
                      (cstart_q <= s1_sl_q) & (s1_sl_q <= cend_q) & sl_ok;

  assign faint_row   = (s1_attr_q.faint & faint_ph) ? (s1_row_q & DOT_MASK) : s1_row_q;
  assign blank_row   = (blink_hit | s1_attr_q.hidden) ? '0 : faint_row;
  assign line_row_px = line_on ? (blank_row | (s1_attr_q.dotted ? DOT_MASK : '1)) : blank_row;
  assign inv_row     = s1_attr_q.inverse ? ~line_row_px : line_row_px;
  assign cur_row     = cursor_hit ? ~inv_row : inv_row;
  assign styled      = sl_ok ? cur_row : '0;

  // Stage 2 next state; a bubble clears the output row.
  always_comb begin
    s2_v_d   = s2_v_q;
    s2_row_d = s2_row_q;
    s2_sl_d  = s2_sl_q;
    if (s2_load) begin
      s2_v_d   = s1_v_q;
      s2_row_d = s1_v_q ? styled : '0;
      s2_sl_d  = s1_v_q ? s1_sl_q : '0;
    end else begin
      s2_v_d   = s2_v_q;
    end
  end

  // Config and pipeline registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q    <= CTRL_RST[CTRL_W-1:0];
      cstart_q  <= SL_W'(GLYPH_H - 2);
      cend_q    <= SL_W'(GLYPH_H - 1);
      s1_v_q    <= 1'b0;
      s1_row_q  <= '0;
      s1_sl_q   <= '0;
      s1_attr_q <= '0;
      s2_v_q    <= 1'b0;
      s2_row_q  <= '0;
      s2_sl_q   <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      cstart_q  <= cstart_d;
      cend_q    <= cend_d;
      s1_v_q    <= s1_v_d;
      s1_row_q  <= s1_row_d;
      s1_sl_q   <= s1_sl_d;
      s1_attr_q <= s1_attr_d;
      s2_v_q    <= s2_v_d;
      s2_row_q  <= s2_row_d;
      s2_sl_q   <= s2_sl_d;
    end
  end

  assign out_valid    = s2_v_q;
  assign out_row      = s2_row_q;
  assign out_scanline = s2_sl_q;

endmodule

// File: tb/tb_glyph_styler_pipe.sv
// Bench for glyph_styler_pipe (W=8, H=16): directed literal cases plus random
// bursts, all scored against a row-level reference model and an in-order queue.
module tb_glyph_styler_pipe;

  localparam int W = 8;
  localparam int H = 16;
  localparam int BS = 5;
  localparam int FC_MOD = 64;

  logic        clk = 1'b0;
  logic        rst_n, frame_tick, cfg_we;
  logic [1:0]  cfg_addr;
  logic [7:0]  cfg_wdata;
  logic        in_valid, in_ready;
  logic [3:0]  in_scanline;
  logic [7:0]  in_bitmap;
  logic [15:0] in_attr;
  logic        out_valid, out_ready;
  logic [7:0]  out_row;
  logic [3:0]  out_scanline;

  int tests = 0;
  int fails = 0;
  int n_out = 0;
  int m_ctrl, m_cs, m_ce, m_fcnt;

  typedef struct packed {
    logic [7:0] row;
    logic [3:0] sl;
  } exp_t;
  exp_t exp_q[$];

  glyph_styler_pipe dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .in_valid(in_valid), .in_ready(in_ready), .in_scanline(in_scanline),
    .in_bitmap(in_bitmap), .in_attr(in_attr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_scanline(out_scanline)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: what a row must look like given the current config and frame count.
  function automatic logic [7:0] model_row(input logic [7:0] bm, input int sl, input logic [15:0] a);
    logic [7:0] r;
    bit blink, line_hit, cur_phase_ok;
    r = bm;
    if (a[0]) for (int i = 0; i < 8; i++) r[i] = bm[7-i];
    if (a[1]) begin
      r = r | (r >> 1);
      if ((m_ctrl & 16) != 0) r = r | (r >> 2);
    end
    if (a[3] && sl < H / 2) r = r >> 1;
    if (a[2] && (m_fcnt % 2) == 1) r = r & 8'h55;
    blink = a[4] && ((m_ctrl & 1) != 0) && (((m_fcnt >> BS) & 1) == 1);
    if (blink || a[6]) r = 8'h00;
    line_hit = (a[7] && sl == H - 1) || (a[8] && (sl == H - 1 || sl == H - 3)) ||
               (a[10] && sl == H / 2 - 1) || (a[11] && sl == 0);
    if (((m_ctrl & 2) != 0) && !blink && line_hit) r = r | (a[9] ? 8'h55 : 8'hFF);
    if (a[5]) r = ~r;
    cur_phase_ok = ((m_ctrl & 8) == 0) || (((m_fcnt >> (BS - 1)) & 1) == 1);
    if (a[12] && ((m_ctrl & 4) != 0) && cur_phase_ok && sl >= m_cs && sl <= m_ce) r = ~r;
    return r;
  endfunction

  task automatic model_reset();
    m_ctrl = 7; m_cs = H - 2; m_ce = H - 1; m_fcnt = 0;
  endtask

  // Compare process: scoreboard on every handshake, hold check on every stall.
  initial begin
    exp_t e;
    logic       held_v;
    logic [7:0] held_row;
    logic [3:0] held_sl;
    held_v = 1'b0; held_row = 8'h00; held_sl = 4'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          chk("hold_valid", int'(out_valid), 1);
          chk("hold_row", int'(out_row), int'(held_row));
          chk("hold_scanline", int'(out_scanline), int'(held_sl));
        end
        if (out_valid && out_ready) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_out: got row 0x%0h, expected no output", out_row);
          end else begin
            e = exp_q.pop_front();
            n_out++;
            if (out_row !== e.row || out_scanline !== e.sl) begin
              fails++;
              $display("FAIL model_row: got row 0x%0h sl %0d, expected row 0x%0h sl %0d",
                       out_row, out_scanline, e.row, e.sl);
            end
          end
        end
        if (in_valid && in_ready) begin
          e.row = model_row(in_bitmap, int'(in_scanline), in_attr);
          e.sl  = in_scanline;
          exp_q.push_back(e);
        end
        held_v   = out_valid && !out_ready;
        held_row = out_row;
        held_sl  = out_scanline;
      end
    end
  end

  task automatic cfg_write(input logic [1:0] addr, input logic [7:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    case (addr)
      2'd0: m_ctrl = int'(data);
      2'd1: m_cs = int'(data) % H;
      2'd2: m_ce = int'(data) % H;
      default: m_fcnt = 0;
    endcase
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(posedge clk); #1;
      frame_tick = 1'b0;
      m_fcnt = (m_fcnt + 1) % FC_MOD;
    end
  endtask

  task automatic tick_and_clear();
    frame_tick = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd3; cfg_wdata = 8'h00;
    @(posedge clk); #1;
    frame_tick = 1'b0; cfg_we = 1'b0;
    m_fcnt = 0;
  endtask

  // Single row on an empty pipe: checks readiness, 2-cycle latency and a literal result.
  task automatic send_one(input string name, input logic [7:0] bm, input logic [3:0] sl,
                          input logic [15:0] a, input logic [7:0] exp);
    in_valid = 1'b1; in_bitmap = bm; in_scanline = sl; in_attr = a; out_ready = 1'b1;
    @(negedge clk);
    chk({name, "_ready"}, int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_lat1"}, int'(out_valid), 0);
    @(negedge clk);
    chk({name, "_valid"}, int'(out_valid), 1);
    chk(name, int'(out_row), int'(exp));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] stall_rows[4];
    int n0, idx, cyc;
    logic acc;
    stall_rows = '{8'hA1, 8'h5B, 8'h3C, 8'hE7};

    rst_n = 1'b0; frame_tick = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'h00;
    in_valid = 1'b0; in_scanline = 4'h0; in_bitmap = 8'h00; in_attr = 16'h0000; out_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_row", int'(out_row), 0);
    chk("reset_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    send_one("bold", 8'h81, 4'd3, 16'h0002, 8'hC1);
    send_one("xmirror_bold", 8'hF0, 4'd3, 16'h0003, 8'h0F);
    send_one("italic_top", 8'h81, 4'd3, 16'h0008, 8'h40);
    send_one("italic_bottom", 8'h81, 4'd8, 16'h0008, 8'h81);
    send_one("underline_15", 8'h00, 4'd15, 16'h0080, 8'hFF);
    send_one("underline_14", 8'h00, 4'd14, 16'h0080, 8'h00);
    send_one("dotted_15", 8'h00, 4'd15, 16'h0280, 8'h55);
    send_one("dbl_under_13", 8'h00, 4'd13, 16'h0100, 8'hFF);
    send_one("strike_7", 8'h00, 4'd7, 16'h0400, 8'hFF);
    send_one("overline_0", 8'h00, 4'd0, 16'h0800, 8'hFF);
    send_one("overline_1", 8'h00, 4'd1, 16'h0800, 8'h00);
    send_one("hidden_inverse", 8'h81, 4'd5, 16'h0060, 8'hFF);
    send_one("hidden_underline", 8'h18, 4'd15, 16'h00C0, 8'hFF);
    send_one("cursor_14", 8'h3C, 4'd14, 16'h1000, 8'hC3);
    send_one("cursor_13", 8'h3C, 4'd13, 16'h1000, 8'h3C);

    cfg_write(2'd0, 8'h17);
    send_one("extra_bold", 8'h81, 4'd3, 16'h0002, 8'hF1);
    cfg_write(2'd0, 8'h05);
    send_one("line_en_off", 8'h00, 4'd15, 16'h0080, 8'h00);

    cfg_write(2'd3, 8'h00);
    cfg_write(2'd0, 8'h0F);
    send_one("cursor_blink_ph0", 8'h3C, 4'd14, 16'h1000, 8'h3C);
    tick(16);
    send_one("cursor_blink_ph1", 8'h3C, 4'd14, 16'h1000, 8'hC3);
    tick(16);
    send_one("cursor_blink_ph0b", 8'h3C, 4'd14, 16'h1000, 8'h3C);
    cfg_write(2'd0, 8'h07);
    cfg_write(2'd3, 8'h00);

    send_one("blink_off", 8'hFF, 4'd15, 16'h0090, 8'hFF);
    tick(32);
    send_one("blink_on", 8'hFF, 4'd15, 16'h0090, 8'h00);
    cfg_write(2'd3, 8'hA5);
    send_one("blink_cleared", 8'hFF, 4'd15, 16'h0090, 8'hFF);
    tick(31);
    tick_and_clear();
    send_one("clear_beats_tick", 8'hFF, 4'd15, 16'h0090, 8'hFF);
    tick(1);
    send_one("faint_ph1", 8'hFF, 4'd3, 16'h0004, 8'h55);
    tick(1);
    send_one("faint_ph0", 8'hFF, 4'd3, 16'h0004, 8'hFF);

    cfg_write(2'd1, 8'd15);
    cfg_write(2'd2, 8'd14);
    send_one("cursor_inverted_14", 8'h3C, 4'd14, 16'h1000, 8'h3C);
    send_one("cursor_inverted_15", 8'h3C, 4'd15, 16'h1000, 8'h3C);
    cfg_write(2'd1, 8'd14);
    cfg_write(2'd2, 8'd15);

    // Four rows with a three-cycle downstream stall in the middle.
    n0 = n_out; idx = 0; cyc = 0;
    while (idx < 4 && cyc < 40) begin
      in_valid = 1'b1; in_bitmap = stall_rows[idx]; in_scanline = 4'(idx + 2); in_attr = 16'h0002;
      out_ready = !(cyc >= 2 && cyc < 5);
      @(negedge clk);
      if (cyc == 3) chk("stall_in_ready", int'(in_ready), 0);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    drain();
    chk("stall_count", n_out - n0, 4);

    // Reset with both stages full and downstream stalled.
    cfg_write(2'd1, 8'd3);
    in_valid = 1'b1; out_ready = 1'b1; in_attr = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      in_bitmap = 8'(8'h11 * (i + 1)); in_scanline = 4'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("reset_mid_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    model_reset();
    @(negedge clk);
    chk("reset_mid_out_valid", int'(out_valid), 0);
    chk("reset_mid_out_row", int'(out_row), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    send_one("cursor_after_reset", 8'h3C, 4'd13, 16'h1000, 8'h3C);

    // Random bursts; config and frame count only change while the pipe is empty.
    for (int b = 0; b < 25; b++) begin
      cfg_write(2'd0, 8'($urandom));
      cfg_write(2'd1, 8'($urandom_range(0, 15)));
      cfg_write(2'd2, 8'($urandom_range(0, 15)));
      tick($urandom_range(0, 40));
      for (int c = 0; c < 60; c++) begin
        in_valid    = ($urandom_range(0, 3) != 0);
        in_bitmap   = 8'($urandom);
        in_scanline = 4'($urandom);
        in_attr     = 16'($urandom) & 16'($urandom);
        out_ready   = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
      end
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
